// File: rtl/survivor_traceback.sv
// Viterbi survivor memory with a fixed-depth traceback that emits one decoded bit per column.
// Optional macro BEST_STATE_START_EN starts each traceback from the lowest-metric state instead of state 0.
module survivor_traceback #(
  parameter int TB_DEPTH  = 8,
  parameter int MEM_DEPTH = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       aen,
  input  logic       acs0_label,
  input  logic       acs1_label,
  input  logic       acs2_label,
  input  logic       acs3_label,
  input  logic       acs4_label,
  input  logic       acs5_label,
  input  logic       acs6_label,
  input  logic       acs7_label,
  input  logic [3:0] acs0_pm_out,
  input  logic [3:0] acs1_pm_out,
  input  logic [3:0] acs2_pm_out,
  input  logic [3:0] acs3_pm_out,
  input  logic [3:0] acs4_pm_out,
  input  logic [3:0] acs5_pm_out,
  input  logic [3:0] acs6_pm_out,
  input  logic [3:0] acs7_pm_out,
  output logic       ready,
  output logic       dout,
  output logic       dout_valid,
  output logic       overrun
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int FW = $clog2(TB_DEPTH + 1);

  typedef enum logic [1:0] {FILL, READY, TRACE, EMIT} state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem [MEM_DEPTH];
  logic [AW-1:0]   wptr_q, k_q, rd_addr;
  logic [FW-1:0]   fill_q, fill_inc;
  logic [2:0]      s_q, start_s;
  logic [7:0]      labels, col;
  logic            accept, last_k;

  function automatic logic [FW-1:0] sat_inc(input logic [FW-1:0] v);
    return (v == FW'(TB_DEPTH)) ? v : v + FW'(1);
  endfunction

`ifdef BEST_STATE_START_EN
  // Strict less-than keeps the lowest index on ties.
  function automatic logic [2:0] min_state(input logic [31:0] pm);
    logic [2:0] best;
    logic [3:0] best_pm;
    best    = 3'd0;
    best_pm = pm[3:0];
    for (int i = 1; i < 8; i++) begin
      if (pm[i*4 +: 4] < best_pm) begin
        best    = 3'(i);
        best_pm = pm[i*4 +: 4];
      end
    end
    return best;
  endfunction

  assign start_s = min_state({acs7_pm_out, acs6_pm_out, acs5_pm_out, acs4_pm_out,
                              acs3_pm_out, acs2_pm_out, acs1_pm_out, acs0_pm_out});
`else
  logic unused_pm;
  assign unused_pm = ^{acs7_pm_out, acs6_pm_out, acs5_pm_out, acs4_pm_out,
                       acs3_pm_out, acs2_pm_out, acs1_pm_out, acs0_pm_out};
  assign start_s   = 3'd0;
`endif

  assign labels   = {acs7_label, acs6_label, acs5_label, acs4_label,
                     acs3_label, acs2_label, acs1_label, acs0_label};
  assign accept   = aen & ready;
  assign fill_inc = sat_inc(fill_q);
  // Newest column sits one behind the write pointer; k walks further back in time.
  assign rd_addr  = wptr_q - AW'(1) - k_q;
  assign col      = mem[rd_addr];
  assign last_k   = (k_q == AW'(TB_DEPTH - 1));

  always_comb begin
    state_d    = state_q;
    ready      = 1'b0;
    dout_valid = 1'b0;
    case (state_q)
      FILL: begin
        ready = 1'b1;
        if (accept && (fill_inc == FW'(TB_DEPTH))) state_d = TRACE;
      end
      READY: begin
        ready = 1'b1;
        if (accept) state_d = TRACE;
      end
      TRACE: begin
        if (last_k) state_d = EMIT;
      end
      EMIT: begin
        dout_valid = 1'b1;
        state_d    = READY;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (accept) mem[wptr_q] <= labels;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= FILL;
      wptr_q  <= '0;
      fill_q  <= '0;
      k_q     <= '0;
      s_q     <= 3'd0;
      dout    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        wptr_q <= wptr_q + AW'(1);
        fill_q <= fill_inc;
      end
      if (aen && !ready) overrun <= 1'b1;
      if (state_q == TRACE) begin
        s_q <= {col[s_q], s_q[2:1]};
        k_q <= k_q + AW'(1);
        if (last_k) dout <= s_q[0];
      end else if (state_d == TRACE) begin
        s_q <= start_s;
        k_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_survivor_traceback.sv
// Scoreboard bench: two instances (TB_DEPTH 8 and 2) driven by directed columns against a trellis model.
module tb_survivor_traceback;

  localparam int D0 = 8;
  localparam int M0 = 16;
  localparam int D1 = 2;
  localparam int M1 = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       aen [2];
  logic [7:0] lab [2];
  logic [3:0] pm  [2][8];
  logic       ready_w [2];
  logic       dout_w  [2];
  logic       dv_w    [2];
  logic       ov_w    [2];

  int         total = 0;
  int         bad   = 0;
  int         busy [2];
  int         fill [2];
  int         hcnt [2];
  int         strobes [2];
  bit         ov_m [2];
  bit         last_dout [2];
  logic [7:0] hist [2][256];
  bit         exp_q0[$];
  bit         exp_q1[$];

  always #5 clock = ~clock;

  survivor_traceback #(.TB_DEPTH(D0), .MEM_DEPTH(M0)) u_dut0 (
    .clock(clock), .reset(reset), .aen(aen[0]),
    .acs0_label(lab[0][0]), .acs1_label(lab[0][1]), .acs2_label(lab[0][2]), .acs3_label(lab[0][3]),
    .acs4_label(lab[0][4]), .acs5_label(lab[0][5]), .acs6_label(lab[0][6]), .acs7_label(lab[0][7]),
    .acs0_pm_out(pm[0][0]), .acs1_pm_out(pm[0][1]), .acs2_pm_out(pm[0][2]), .acs3_pm_out(pm[0][3]),
    .acs4_pm_out(pm[0][4]), .acs5_pm_out(pm[0][5]), .acs6_pm_out(pm[0][6]), .acs7_pm_out(pm[0][7]),
    .ready(ready_w[0]), .dout(dout_w[0]), .dout_valid(dv_w[0]), .overrun(ov_w[0])
  );

  survivor_traceback #(.TB_DEPTH(D1), .MEM_DEPTH(M1)) u_dut1 (
    .clock(clock), .reset(reset), .aen(aen[1]),
    .acs0_label(lab[1][0]), .acs1_label(lab[1][1]), .acs2_label(lab[1][2]), .acs3_label(lab[1][3]),
    .acs4_label(lab[1][4]), .acs5_label(lab[1][5]), .acs6_label(lab[1][6]), .acs7_label(lab[1][7]),
    .acs0_pm_out(pm[1][0]), .acs1_pm_out(pm[1][1]), .acs2_pm_out(pm[1][2]), .acs3_pm_out(pm[1][3]),
    .acs4_pm_out(pm[1][4]), .acs5_pm_out(pm[1][5]), .acs6_pm_out(pm[1][6]), .acs7_pm_out(pm[1][7]),
    .ready(ready_w[1]), .dout(dout_w[1]), .dout_valid(dv_w[1]), .overrun(ov_w[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] start_of(input int inst);
    logic [2:0] b;
    b = 3'd0;
`ifdef BEST_STATE_START_EN
    for (int i = 1; i < 8; i++)
      if (pm[inst][i] < pm[inst][b]) b = 3'(i);
`endif
    return b;
  endfunction

  // Walk the survivor path backwards from the newest accepted column.
  function automatic bit trace_bit(input int inst, input logic [2:0] s0);
    int         d;
    logic [2:0] s;
    logic [7:0] c;
    bit         r;
    d = (inst == 0) ? D0 : D1;
    s = s0;
    r = 1'b0;
    for (int k = 0; k < d; k++) begin
      c = hist[inst][(hcnt[inst] - 1 - k) % 256];
      if (k == d - 1) r = s[0];
      s = {c[s], s[2:1]};
    end
    return r;
  endfunction

  task automatic model_edge(input int inst);
    int d;
    bit e;
    d = (inst == 0) ? D0 : D1;
    if (busy[inst] > 0) begin
      if (aen[inst]) ov_m[inst] = 1'b1;
      busy[inst]--;
    end else if (aen[inst]) begin
      hist[inst][hcnt[inst] % 256] = lab[inst];
      hcnt[inst]++;
      if (fill[inst] < d) fill[inst]++;
      if (fill[inst] == d) begin
        e = trace_bit(inst, start_of(inst));
        if (inst == 0) exp_q0.push_back(e);
        else           exp_q1.push_back(e);
        busy[inst] = d + 1;
      end
    end
  endtask

  task automatic step(input int inst, input bit a, input logic [7:0] l);
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("ready%0d", i), ready_w[i], (busy[i] == 0));
      check($sformatf("overrun%0d", i), ov_w[i], ov_m[i]);
    end
    aen[0] = 1'b0;
    aen[1] = 1'b0;
    aen[inst] = a;
    lab[inst] = l;
    @(posedge clock);
    model_edge(0);
    model_edge(1);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 1'b0, 8'h00);
  endtask

  task automatic reset_checks(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_ready%0d", tag, i), ready_w[i], 1);
      check($sformatf("%s_valid%0d", tag, i), dv_w[i], 0);
      check($sformatf("%s_dout%0d", tag, i), dout_w[i], 0);
      check($sformatf("%s_overrun%0d", tag, i), ov_w[i], 0);
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock);
    aen[0] = 1'b0;
    aen[1] = 1'b0;
    #2 reset = 1'b1;
    #1 reset_checks(tag);
    for (int i = 0; i < 2; i++) begin
      busy[i] = 0; fill[i] = 0; ov_m[i] = 1'b0; last_dout[i] = 1'b0; strobes[i] = 0;
    end
    exp_q0.delete();
    exp_q1.delete();
    @(negedge clock);
    reset = 1'b0;
  endtask

  always @(negedge clock) begin
    bit e;
    if (!reset) begin
      if (dv_w[0]) begin
        strobes[0]++;
        if (exp_q0.size() == 0) begin
          total++; bad++;
          $display("FAIL strobe0: got unexpected dout_valid expected none");
        end else begin
          e = exp_q0.pop_front();
          check("dout0", dout_w[0], e);
          last_dout[0] = e;
        end
      end else check("hold0", dout_w[0], last_dout[0]);
      if (dv_w[1]) begin
        strobes[1]++;
        if (exp_q1.size() == 0) begin
          total++; bad++;
          $display("FAIL strobe1: got unexpected dout_valid expected none");
        end else begin
          e = exp_q1.pop_front();
          check("dout1", dout_w[1], e);
          last_dout[1] = e;
        end
      end else check("hold1", dout_w[1], last_dout[1]);
    end
  end

  initial begin
    int acc;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      aen[i] = 1'b0; lab[i] = 8'h00; busy[i] = 0; fill[i] = 0; hcnt[i] = 0;
      ov_m[i] = 1'b0; last_dout[i] = 1'b0; strobes[i] = 0;
      for (int j = 0; j < 8; j++) pm[i][j] = 4'd0;
    end
    #3 reset_checks("por");
    @(negedge clock);
    reset = 1'b0;

    // All-zero labels: only the 8th column strobes, dout=0.
    repeat (8) step(0, 1'b1, 8'h00);
    idle(12);
    check("allzero_strobes", strobes[0], 1);

    // All-one labels: path 0,4,6,7,... gives dout=1.
    do_reset("rst_a");
    repeat (8) step(0, 1'b1, 8'hFF);
    idle(12);
    check("allone_strobes", strobes[0], 1);

    // Columns arriving during traceback are dropped and latch overrun.
    step(0, 1'b1, 8'h5A);
    repeat (4) step(0, 1'b1, 8'h00);
    idle(8);
    step(0, 1'b1, 8'h96);
    idle(12);

    // Reset a few cycles into a traceback aborts it; decoding restarts from empty.
    do_reset("rst_b");
    repeat (8) step(0, 1'b1, 8'h33);
    step(0, 1'b1, 8'hC3);
    idle(2);
    do_reset("rst_mid");
    repeat (7) step(0, 1'b1, 8'h0F);
    idle(3);
    check("refill_nostrobe", strobes[0], 0);
    step(0, 1'b1, 8'h0F);
    idle(12);
    check("refill_strobe", strobes[0], 1);

    // Shallow instance: state 3 has the best metric.
    for (int j = 0; j < 8; j++) pm[1][j] = 4'd9;
    pm[1][3] = 4'd2;
    step(1, 1'b1, 8'h00);
    step(1, 1'b1, 8'h00);
    idle(6);
    step(1, 1'b1, 8'hFF);
    idle(6);
    check("shallow_strobes", strobes[1], 2);

    // Random columns, spaced to be accepted, across write-pointer wrap.
    do_reset("rst_c");
    acc = 0;
    while (acc < 40) begin
      if (busy[0] == 0) begin
        for (int j = 0; j < 8; j++) pm[0][j] = 4'($urandom_range(0, 15));
        step(0, 1'b1, 8'($urandom_range(0, 255)));
        acc++;
      end else step(0, 1'b0, 8'h00);
    end
    idle(12);
    check("random_strobes", strobes[0], 33);

    check("queue0_empty", exp_q0.size(), 0);
    check("queue1_empty", exp_q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
